pll_reconfig_ctrl: RTL

Supervisory controller for a Gowin rPLL that is configured with dynamic IDIV/FBDIV/ODIV selection. It runs on the free-running PLL reference clock. It drives the PLL's RESET and IDSEL/FBDSEL/ODSEL inputs from a parametrised table of frequency profiles, and qualifies LOCK with a debounce window. It retries failed locks with a timeout, and handles runtime profile-switch requests and loss-of-lock recovery, so downstream logic sees a single clean `locked` qualifier.

---
 rtl/pll_reconfig_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pll_reconfig_ctrl.sv
// Supervisor for a Gowin rPLL: applies IDSEL/FBDSEL/ODSEL profiles, sequences RESET,
// debounces LOCK, retries on timeout and exposes a single qualified `locked`.
module pll_reconfig_ctrl #(
  parameter int NUM_PROFILES = 4,
  parameter logic [NUM_PROFILES*6-1:0] PROF_IDSEL  = {18'd0, 6'd57},
  parameter logic [NUM_PROFILES*6-1:0] PROF_FBDSEL = {18'd0, 6'd38},
  parameter logic [NUM_PROFILES*6-1:0] PROF_ODSEL  = {18'd0, 6'd56},
  parameter int DEFAULT_PROFILE     = 0,
  parameter int RESET_HOLD_CYCLES   = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRIES         = 3,
  parameter int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
  input  logic          clkin,
  input  logic          resetn,
  input  logic          pll_lock,
  input  logic          req_valid,
  input  logic [PW-1:0] req_profile,
  output logic          req_ready,
  output logic          req_err,
  output logic          pll_reset,
  output logic [5:0]    idsel,
  output logic [5:0]    fbdsel,
  output logic [5:0]    odsel,
  output logic [PW-1:0] cur_profile,
  output logic          locked,
  output logic          busy,
  output logic          fault,
  output logic          lol
);

  localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES + 1) : 1;
  localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES + 1) : 1;
  localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES + 1) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [PW:0]   NP        = (PW+1)'(NUM_PROFILES);
  localparam logic [PW-1:0] DEF_PROF  = PW'(DEFAULT_PROFILE);
  localparam logic [5:0]    DEF_ID    = PROF_IDSEL[6*DEFAULT_PROFILE +: 6];
  localparam logic [5:0]    DEF_FBD   = PROF_FBDSEL[6*DEFAULT_PROFILE +: 6];
  localparam logic [5:0]    DEF_OD    = PROF_ODSEL[6*DEFAULT_PROFILE +: 6];

  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_LOCKED, S_FAULT} state_t;

  function automatic logic [5:0] lookup(input logic [NUM_PROFILES*6-1:0] tbl,
                                        input logic [PW-1:0] idx);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < NUM_PROFILES; i++)
      if (int'(idx) == i) r = tbl[6*i +: 6];
    return r;
  endfunction

  logic          lk_meta, lk;
  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [SW-1:0] stb_cnt, stb_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic          req_ok, req_bad, lol_ev;
  logic          pll_reset_d, locked_d, busy_d, fault_d, ready_d;

  // LOCK is asynchronous to clkin; nothing downstream may look at it raw.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= pll_lock;
      lk      <= lk_meta;
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state       <= S_HOLD;
      hold_cnt    <= '0;
      stb_cnt     <= '0;
      tmo_cnt     <= '0;
      retry       <= '0;
      cur_profile <= DEF_PROF;
      idsel       <= DEF_ID;
      fbdsel      <= DEF_FBD;
      odsel       <= DEF_OD;
      pll_reset   <= 1'b1;
      locked      <= 1'b0;
      busy        <= 1'b1;
      fault       <= 1'b0;
      req_ready   <= 1'b0;
      req_err     <= 1'b0;
      lol         <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      stb_cnt   <= stb_nxt;
      tmo_cnt   <= tmo_nxt;
      retry     <= retry_nxt;
      pll_reset <= pll_reset_d;
      locked    <= locked_d;
      busy      <= busy_d;
      fault     <= fault_d;
      req_ready <= ready_d;
      req_err   <= req_bad;
      lol       <= lol_ev;
      if (req_ok) begin
        cur_profile <= req_profile;
        idsel       <= lookup(PROF_IDSEL, req_profile);
        fbdsel      <= lookup(PROF_FBDSEL, req_profile);
        odsel       <= lookup(PROF_ODSEL, req_profile);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    stb_nxt   = stb_cnt;
    tmo_nxt   = tmo_cnt;
    retry_nxt = retry;
    lol_ev    = 1'b0;
    req_ok    = req_valid & req_ready & ({1'b0, req_profile} < NP);
    req_bad   = req_valid & req_ready & ({1'b0, req_profile} >= NP);

    case (state)
      S_HOLD: begin
        tmo_nxt = '0;
        stb_nxt = '0;
        if (hold_cnt == HOLD_LAST) begin
          hold_nxt  = '0;
          state_nxt = S_WAIT;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        tmo_nxt = tmo_cnt + 1'b1;
        stb_nxt = lk ? stb_cnt + 1'b1 : '0;
        // Timeout takes precedence over a lock that completes on the same cycle.
        if (tmo_cnt == TMO_LAST) begin
          if (retry < RETRY_MAX) begin
            retry_nxt = retry + 1'b1;
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_FAULT;
          end
        end else if (lk && stb_cnt == STB_LAST) begin
          retry_nxt = '0;
          state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (!lk) begin
          lol_ev    = 1'b1;
          retry_nxt = '0;
          state_nxt = S_HOLD;
        end
      end
      default: ;
    endcase

    // An accepted request overrides everything, including a simultaneous loss of lock.
    if (req_ok) begin
      state_nxt = S_HOLD;
      hold_nxt  = '0;
      retry_nxt = '0;
    end
  end

  always_comb begin
    pll_reset_d = (state_nxt == S_HOLD) || (state_nxt == S_FAULT);
    locked_d    = (state_nxt == S_LOCKED);
    fault_d     = (state_nxt == S_FAULT);
    busy_d      = (state_nxt == S_HOLD) || (state_nxt == S_WAIT);
    ready_d     = locked_d || fault_d;
  end

endmodule
